// File: rtl/flash_sequence_player_if.sv
// Handshake and status bundle between the game controller and the LED flash sequencer.
// The controller owns start/abort/round/pattern; the sequencer owns the playback status.
interface flash_sequence_player_if;
  logic       start;
  logic       abort;
  logic [2:0] round;
  logic [7:0] pattern;
  logic       busy;
  logic       done;
  logic [1:0] led_flash;
  logic [2:0] idx;

  modport master (
    output start, abort, round, pattern,
    input  busy, done, led_flash, idx
  );

  modport slave (
    input  start, abort, round, pattern,
    output busy, done, led_flash, idx
  );
endinterface

// File: rtl/flash_sequence_player.sv
// Simon LED flash sequencer: latches a pattern and round on start, then plays
// bits 0..round as timed lit/dark phases on two LEDs and pulses done at the end.
module flash_sequence_player #(
  parameter int TICK_DIV   = 100000,
  parameter int LEAD_TICKS = 500,
  parameter int ON_TICKS   = 400,
  parameter int GAP_TICKS  = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  flash_sequence_player_if.slave bus
);

  localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_TICKS = (LEAD_TICKS > ON_TICKS)
                           ? ((LEAD_TICKS > GAP_TICKS) ? LEAD_TICKS : GAP_TICKS)
                           : ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS);
  localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] LEAD_LAST = TICK_W'(LEAD_TICKS - 1);
  localparam logic [TICK_W-1:0] ON_LAST   = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_ON,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state, state_d;
  logic [PRE_W-1:0]    pre_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TICK_W-1:0]   phase_last;
  logic [2:0]          round_lat;
  logic [7:0]          pattern_lat;
  logic [2:0]          idx_q, idx_d;
  logic                latch_en;
  logic                tick;
  logic                phase_end;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          led_q, led_d;

  assign tick      = (pre_cnt == PRE_LAST);
  assign phase_end = tick && (tick_cnt == phase_last);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    phase_last = '0;
    case (state)
      S_LEAD:  phase_last = LEAD_LAST;
      S_ON:    phase_last = ON_LAST;
      S_GAP:   phase_last = GAP_LAST;
      default: phase_last = '0;
    endcase
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx_q;
    latch_en = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = S_LEAD;
          idx_d    = '0;
          latch_en = 1'b1;
        end
      end
      S_LEAD: if (phase_end) state_d = S_ON;
      S_ON:   if (phase_end) state_d = S_GAP;
      S_GAP: begin
        if (phase_end) begin
          if (idx_q == round_lat) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_ON;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any phase transition and leaves idx where playback stopped.
    if (state != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    led_d  = 2'b00;
    if (state_d == S_ON) begin
      led_d = pattern_lat[idx_d] ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state       <= S_IDLE;
      pre_cnt     <= '0;
      tick_cnt    <= '0;
      round_lat   <= '0;
      pattern_lat <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      led_q       <= 2'b00;
    end else begin
      state  <= state_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      led_q  <= led_d;

      if (latch_en) begin
        round_lat   <= bus.round;
        pattern_lat <= bus.pattern;
      end

      // Timing restarts on every state entry so each phase is exactly N ticks long.
      if (state_d != state || state == S_IDLE) begin
        pre_cnt  <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        pre_cnt  <= '0;
        tick_cnt <= tick_cnt + TICK_W'(1);
      end else begin
        pre_cnt  <= pre_cnt + PRE_W'(1);
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.led_flash = led_q;
  assign bus.idx       = idx_q;

endmodule

// File: tb/tb_flash_sequence_player.sv
// Self-checking bench for flash_sequence_player: table-driven playbacks, hand-written
// abort/reset/ignore sequences and randomized playbacks against a timeline model.
module tb_flash_sequence_player;

  localparam int TD   = 2;
  localparam int LEAD = 1;
  localparam int ON   = 3;
  localparam int GAP  = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  flash_sequence_player_if bus ();

  flash_sequence_player #(
    .TICK_DIV  (TD),
    .LEAD_TICKS(LEAD),
    .ON_TICKS  (ON),
    .GAP_TICKS (GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] r;
    logic [7:0] p;
    int         lat;
    int         flashes;
    int         ones;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs t cycles after busy rises, from the phase-length rules alone.
  function automatic void model(input int r, input logic [7:0] p, input int t,
                                output logic b, output logic d,
                                output logic [1:0] l, output int ix);
    int lead, per, total, k, w;
    lead  = LEAD * TD;
    per   = (ON + GAP) * TD;
    total = lead + (r + 1) * per;
    b = 1'b0; d = 1'b0; l = 2'b00; ix = r;
    if (t < lead) begin
      b = 1'b1; ix = 0;
    end else if (t < total) begin
      k  = (t - lead) / per;
      w  = (t - lead) % per;
      b  = 1'b1;
      ix = k;
      if (w < ON * TD) l = p[k] ? 2'b10 : 2'b01;
    end else if (t == total) begin
      b = 1'b1; d = 1'b1;
    end
  endfunction

  function automatic int play_len(input int r);
    return LEAD * TD + (r + 1) * (ON + GAP) * TD;
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  // Starts a playback and compares every cycle; optional abort and busy-time disturbance.
  task automatic run_play(input int r, input logic [7:0] p, input int abort_at, input bit poke,
                          output int latency, output int flashes, output int ones);
    int         total, limit;
    logic       eb, ed;
    logic [1:0] el, prev;
    int         eix;
    logic [6:0] act, exp;
    total   = play_len(r);
    limit   = (abort_at >= 0) ? abort_at + 2 : total + 2;
    latency = -1; flashes = 0; ones = 0; prev = 2'b00;
    bus.start = 1'b1; bus.abort = 1'b0; bus.round = 3'(r); bus.pattern = p;
    tick_edge();
    bus.start = 1'b0;
    for (int t = 0; t <= limit; t++) begin
      model(r, p, t, eb, ed, el, eix);
      act = {bus.busy, bus.done, bus.led_flash, bus.idx};
      exp = {eb, ed, el, 3'(eix)};
      if (abort_at >= 0 && t > abort_at) begin
        act[2:0] = 3'b000;
        exp      = 7'b0;
      end
      check($sformatf("play r=%0d p=%02h t=%0d {busy,done,led,idx}", r, p, t), 32'(act), 32'(exp));
      if (bus.done && latency < 0) latency = t;
      if (bus.led_flash != 2'b00 && prev == 2'b00) begin
        flashes++;
        if (bus.led_flash == 2'b10) ones++;
      end
      prev      = bus.led_flash;
      bus.abort = (t == abort_at);
      bus.start = poke && (t < total) && ($urandom_range(1) == 1);
      if (poke) begin
        bus.round   = 3'($urandom_range(7));
        bus.pattern = 8'($urandom);
      end
      tick_edge();
    end
    bus.start = 1'b0; bus.abort = 1'b0;
  endtask

  initial begin
    int   lat, fl, on1;
    bit   bad;
    tests = 0;
    fails = 0;

    vecs[0] = '{r: 3'd2, p: 8'h05, lat: 32, flashes: 3, ones: 2};
    vecs[1] = '{r: 3'd0, p: 8'h00, lat: 12, flashes: 1, ones: 0};
    vecs[2] = '{r: 3'd7, p: 8'hA5, lat: 82, flashes: 8, ones: 4};
    vecs[3] = '{r: 3'd3, p: 8'hF0, lat: 42, flashes: 4, ones: 0};
    vecs[4] = '{r: 3'd5, p: 8'h3C, lat: 62, flashes: 6, ones: 4};

    // Reset held with start asserted: nothing may start.
    rst_n = 1'b0;
    bus.start = 1'b1; bus.abort = 1'b0; bus.round = 3'd3; bus.pattern = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick_edge();
      check($sformatf("reset cycle %0d outputs", i),
            32'({bus.busy, bus.done, bus.led_flash, bus.idx}), 32'd0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick_edge();
    check("idle after reset busy", 32'(bus.busy), 32'd0);

    // Table of full playbacks; the A5 entry also pokes start/round/pattern while busy.
    for (int i = 0; i < 5; i++) begin
      run_play(vecs[i].r, vecs[i].p, -1, (i == 2), lat, fl, on1);
      check($sformatf("vec%0d done latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d flash count", i), 32'(fl), 32'(vecs[i].flashes));
      check($sformatf("vec%0d left flashes", i), 32'(on1), 32'(vecs[i].ones));
      tick_edge();
    end

    // Start and abort together in IDLE: abort wins.
    bus.start = 1'b1; bus.abort = 1'b1; bus.round = 3'd1; bus.pattern = 8'h03;
    tick_edge();
    bus.start = 1'b0; bus.abort = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy || bus.done || bus.led_flash != 2'b00) bad = 1'b1;
      tick_edge();
    end
    check("start+abort in idle ignored", 32'(bad), 32'd0);

    // Abort in the second lit phase, then restart one cycle later from idx 0.
    run_play(2, 8'h05, 14, 1'b0, lat, fl, on1);
    check("aborted play no done", 32'(lat), 32'hFFFF_FFFF);
    run_play(1, 8'h02, -1, 1'b0, lat, fl, on1);
    check("restart after abort latency", 32'(lat), 32'd22);

    // Reset in mid-playback ends it without a done pulse.
    tick_edge();
    bus.start = 1'b1; bus.round = 3'd4; bus.pattern = 8'h55;
    tick_edge();
    bus.start = 1'b0;
    repeat (5) tick_edge();
    rst_n = 1'b0;
    tick_edge();
    check("mid-play reset outputs", 32'({bus.busy, bus.done, bus.led_flash, bus.idx}), 32'd0);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.busy || bus.done) bad = 1'b1;
      tick_edge();
    end
    check("no activity after mid-play reset", 32'(bad), 32'd0);

    // Randomized playbacks against the model.
    for (int i = 0; i < 8; i++) begin
      int         rr;
      logic [7:0] pp;
      rr = int'($urandom_range(7));
      pp = 8'($urandom);
      run_play(rr, pp, -1, ($urandom_range(1) == 1), lat, fl, on1);
      check($sformatf("rand%0d latency", i), 32'(lat), 32'(play_len(rr)));
      check($sformatf("rand%0d flash count", i), 32'(fl), 32'(rr + 1));
      tick_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
